cells_commit: RTL and testbench

//  Consumer end of the next-state buffer. After cells_next_state has written a full generation into the

---
 rtl/cells_pkg.sv | 14 +
 rtl/cells_commit.sv | 113 +++++++++++
 tb/tb_cells_commit.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/cells_pkg.sv
// Shared cell encoding and commit-sweep state type for the cells datapath.
package cells_pkg;

  localparam int unsigned CELL_WIDTH = 2;

  typedef logic [CELL_WIDTH-1:0] cell_t;

  localparam cell_t CELL_EMPTY = 2'b00;
  localparam cell_t CELL_SAND  = 2'b01;
  localparam cell_t CELL_WATER = 2'b10;

  typedef enum logic [1:0] {IDLE, PRIME, STREAM, DONE} commit_state_t;

endpackage

// File: rtl/cells_commit.sv
// Copies the next-state RAM into VRAM cell by cell, optionally clearing RAM behind the sweep,
// and reports the number of non-empty cells committed.
module cells_commit
  import cells_pkg::*;
#(
  parameter int unsigned ACTIVE_COLUMNS = 640,
  parameter int unsigned ACTIVE_ROWS    = 480,
  parameter int unsigned ADDR_WIDTH     = $clog2(ACTIVE_COLUMNS * ACTIVE_ROWS),
  parameter int unsigned DATA_WIDTH     = 2,
  parameter bit          CLEAR_RAM      = 1'b1
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  start_i,
  input  logic                  stall_i,
  input  logic [DATA_WIDTH-1:0] ram_rd_data,
  output logic [ADDR_WIDTH-1:0] ram_rd_address_o,
  output logic [ADDR_WIDTH-1:0] ram_wr_address_o,
  output logic [DATA_WIDTH-1:0] ram_wr_data_o,
  output logic                  ram_wr_en_o,
  output logic [ADDR_WIDTH-1:0] vram_wr_address_o,
  output logic [DATA_WIDTH-1:0] vram_wr_data_o,
  output logic                  vram_wr_en_o,
  output logic                  busy_o,
  output logic                  done_o,
  output logic [ADDR_WIDTH:0]   live_count_o
);

  localparam int unsigned          NumCells = ACTIVE_COLUMNS * ACTIVE_ROWS;
  localparam logic [ADDR_WIDTH-1:0] LastPtr = ADDR_WIDTH'(NumCells - 1);

  commit_state_t         state_q, state_d;
  logic [ADDR_WIDTH-1:0] ptr_q, ptr_d;
  logic [ADDR_WIDTH:0]   count_q, count_d;
  logic [ADDR_WIDTH:0]   live_count_q, live_count_d;
  logic                  cell_live;

  assign cell_live     = (ram_rd_data != DATA_WIDTH'(CELL_EMPTY));
  assign ram_wr_data_o = '0;
  assign live_count_o  = live_count_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q      <= IDLE;
      ptr_q        <= '0;
      count_q      <= '0;
      live_count_q <= '0;
    end else begin
      state_q      <= state_d;
      ptr_q        <= ptr_d;
      count_q      <= count_d;
      live_count_q <= live_count_d;
    end
  end

  always_comb begin
    state_d           = state_q;
    ptr_d             = ptr_q;
    count_d           = count_q;
    live_count_d      = live_count_q;
    ram_rd_address_o  = '0;
    ram_wr_address_o  = '0;
    ram_wr_en_o       = 1'b0;
    vram_wr_address_o = '0;
    vram_wr_data_o    = '0;
    vram_wr_en_o      = 1'b0;
    busy_o            = 1'b0;
    done_o            = 1'b0;

    case (state_q)
      IDLE: begin
        if (start_i) begin
          ptr_d   = '0;
          count_d = '0;
          state_d = PRIME;
        end
      end
      PRIME: begin
        busy_o           = 1'b1;
        ram_rd_address_o = '0;
        state_d          = STREAM;
      end
      STREAM: begin
        busy_o = 1'b1;
        if (stall_i) begin
          // Re-read the pending cell so its data is valid again when the stall lifts.
          ram_rd_address_o = ptr_q;
        end else begin
          vram_wr_en_o      = 1'b1;
          vram_wr_address_o = ptr_q;
          vram_wr_data_o    = ram_rd_data;
          ram_wr_en_o       = CLEAR_RAM;
          ram_wr_address_o  = ptr_q;
          count_d           = count_q + (ADDR_WIDTH + 1)'(cell_live);
          if (ptr_q == LastPtr) begin
            state_d = DONE;
          end else begin
            ptr_d            = ptr_q + ADDR_WIDTH'(1);
            ram_rd_address_o = ptr_q + ADDR_WIDTH'(1);
          end
        end
      end
      DONE: begin
        busy_o       = 1'b1;
        done_o       = 1'b1;
        live_count_d = count_q;
        state_d      = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_cells_commit.sv
// Directed bench for cells_commit on a 4x3 grid, one instance clearing RAM and one not.
module tb_cells_commit;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 2;

  logic clk = 1'b0;
  logic reset = 1'b1;
  logic start = 1'b0;
  logic stall = 1'b0;

  always #5 clk = ~clk;

  // Instance 1: CLEAR_RAM=1
  logic [DW-1:0] rd1;
  logic [AW-1:0] ra1, wa1, va1;
  logic [DW-1:0] wd1, vd1;
  logic          we1, vwe1, busy1, done1;
  logic [AW:0]   live1;

  // Instance 2: CLEAR_RAM=0
  logic [DW-1:0] rd2;
  logic [AW-1:0] ra2, wa2, va2;
  logic [DW-1:0] wd2, vd2;
  logic          we2, vwe2, busy2, done2;
  logic [AW:0]   live2;

  cells_commit #(
    .ACTIVE_COLUMNS(4), .ACTIVE_ROWS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_RAM(1'b1)
  ) dut (
    .clk_i(clk), .reset_i(reset), .start_i(start), .stall_i(stall), .ram_rd_data(rd1),
    .ram_rd_address_o(ra1), .ram_wr_address_o(wa1), .ram_wr_data_o(wd1), .ram_wr_en_o(we1),
    .vram_wr_address_o(va1), .vram_wr_data_o(vd1), .vram_wr_en_o(vwe1),
    .busy_o(busy1), .done_o(done1), .live_count_o(live1)
  );

  cells_commit #(
    .ACTIVE_COLUMNS(4), .ACTIVE_ROWS(3), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .CLEAR_RAM(1'b0)
  ) dut_nc (
    .clk_i(clk), .reset_i(reset), .start_i(start), .stall_i(stall), .ram_rd_data(rd2),
    .ram_rd_address_o(ra2), .ram_wr_address_o(wa2), .ram_wr_data_o(wd2), .ram_wr_en_o(we2),
    .vram_wr_address_o(va2), .vram_wr_data_o(vd2), .vram_wr_en_o(vwe2),
    .busy_o(busy2), .done_o(done2), .live_count_o(live2)
  );

  // Memory models and write monitors; "load" preloads RAM, poisons VRAM with 3 and clears tallies.
  logic [DW-1:0] img   [16];
  logic [DW-1:0] ram1  [16];
  logic [DW-1:0] ram2  [16];
  logic [DW-1:0] vram1 [16];
  logic [DW-1:0] vram2 [16];
  logic          load = 1'b0;
  int            nvw1, nvw2, ndone1, ndone2, nwe2, ord_err1, ord_err2;
  logic [AW-1:0] exp1, exp2;

  always @(posedge clk) begin
    if (load) begin
      for (int i = 0; i < 16; i++) begin
        ram1[i]  <= img[i];
        ram2[i]  <= img[i];
        vram1[i] <= 2'b11;
        vram2[i] <= 2'b11;
      end
      nvw1 <= 0; nvw2 <= 0; ndone1 <= 0; ndone2 <= 0; nwe2 <= 0;
      ord_err1 <= 0; ord_err2 <= 0; exp1 <= '0; exp2 <= '0;
    end else begin
      rd1 <= ram1[ra1];
      rd2 <= ram2[ra2];
      if (we1) ram1[wa1] <= wd1;
      if (we2) begin
        ram2[wa2] <= wd2;
        nwe2 <= nwe2 + 1;
      end
      if (vwe1) begin
        vram1[va1] <= vd1;
        nvw1 <= nvw1 + 1;
        exp1 <= exp1 + 1'b1;
        if (va1 != exp1) ord_err1 <= ord_err1 + 1;
      end
      if (vwe2) begin
        vram2[va2] <= vd2;
        nvw2 <= nvw2 + 1;
        exp2 <= exp2 + 1'b1;
        if (va2 != exp2) ord_err2 <= ord_err2 + 1;
      end
      if (done1) ndone1 <= ndone1 + 1;
      if (done2) ndone2 <= ndone2 + 1;
    end
  end

  int pass_cnt = 0;
  int total = 0;
  int kind_q = 0;

  // 0: mixed pattern (4 live), 1: all empty, 2: all sand
  function automatic logic [DW-1:0] pattern(input int kind, input int i);
    logic [DW-1:0] mix [12];
    mix = '{2'd1, 2'd0, 2'd2, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd0, 2'd1, 2'd0, 2'd2};
    if (i >= 12) return 2'd0;
    case (kind)
      0:       return mix[i];
      1:       return 2'd0;
      default: return 2'd1;
    endcase
  endfunction

  task automatic prep(input int kind);
    kind_q = kind;
    @(negedge clk);
    for (int i = 0; i < 16; i++) img[i] = pattern(kind, i);
    load = 1'b1;
    @(negedge clk);
    load = 1'b0;
  endtask

  // Runs one sweep from the start pulse (cycle 0). Returns first done cycle or -1.
  // If reset_cyc >= 0 the sweep is cut short with reset asserted at that cycle.
  task automatic run_sweep(input bit stall_en, input int restart_cyc, input int reset_cyc,
                           output int done_cyc);
    int cyc;
    done_cyc = -1;
    start = 1'b1;
    cyc = 0;
    while (cyc < 40) begin
      @(negedge clk);
      cyc++;
      start = (cyc == restart_cyc);
      stall = stall_en && ((cyc >= 7 && cyc <= 9) || cyc == 16);
      if (cyc == reset_cyc) begin
        reset = 1'b1;
        stall = 1'b0;
        start = 1'b0;
        return;
      end
      if (done1 && done_cyc < 0) done_cyc = cyc;
    end
    stall = 1'b0;
  endtask

  task automatic check_result(input string tag, input int done_cyc, input int exp_done,
                              input int exp_live);
    int vbad, rbad;
    vbad = 0;
    rbad = 0;
    for (int i = 0; i < 12; i++) begin
      if (vram1[i] !== pattern(kind_q, i)) vbad++;
      if (ram1[i] !== 2'd0) rbad++;
    end
    total++;
    if (done_cyc !== exp_done) $display("FAIL %s done_cycle got %0d want %0d", tag, done_cyc, exp_done);
    else pass_cnt++;
    total++;
    if (live1 !== (AW + 1)'(exp_live)) $display("FAIL %s live_count got %0d want %0d", tag, live1, exp_live);
    else pass_cnt++;
    total++;
    if (vbad !== 0) $display("FAIL %s vram_content bad_cells %0d want 0", tag, vbad);
    else pass_cnt++;
    total++;
    if (rbad !== 0) $display("FAIL %s ram_cleared bad_cells %0d want 0", tag, rbad);
    else pass_cnt++;
    total++;
    if (nvw1 !== 12 || ord_err1 !== 0)
      $display("FAIL %s vram_writes got %0d order_err %0d want 12/0", tag, nvw1, ord_err1);
    else pass_cnt++;
    total++;
    if (ndone1 !== 1) $display("FAIL %s done_pulses got %0d want 1", tag, ndone1);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    total++;
    if (busy1 !== 1'b0 || done1 !== 1'b0) $display("FAIL reset busy/done got %b%b want 00", busy1, done1);
    else pass_cnt++;
    total++;
    if (vwe1 !== 1'b0 || we1 !== 1'b0) $display("FAIL reset strobes got %b%b want 00", vwe1, we1);
    else pass_cnt++;
    total++;
    if (live1 !== '0) $display("FAIL reset live_count got %0d want 0", live1);
    else pass_cnt++;
    reset = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_basic();
    int d;
    prep(0);
    run_sweep(1'b0, -1, -1, d);
    check_result("basic", d, 14, 4);
  endtask

  task automatic test_no_clear();
    int d, vbad, rbad;
    prep(0);
    run_sweep(1'b0, -1, -1, d);
    vbad = 0;
    rbad = 0;
    for (int i = 0; i < 12; i++) begin
      if (vram2[i] !== pattern(0, i)) vbad++;
      if (ram2[i] !== pattern(0, i)) rbad++;
    end
    total++;
    if (vbad !== 0) $display("FAIL noclear vram_content bad_cells %0d want 0", vbad);
    else pass_cnt++;
    total++;
    if (rbad !== 0) $display("FAIL noclear ram_intact bad_cells %0d want 0", rbad);
    else pass_cnt++;
    total++;
    if (nwe2 !== 0) $display("FAIL noclear ram_wr_en_cycles got %0d want 0", nwe2);
    else pass_cnt++;
    total++;
    if (live2 !== 5'd4 || ndone2 !== 1) $display("FAIL noclear live/done got %0d/%0d want 4/1", live2, ndone2);
    else pass_cnt++;
  endtask

  task automatic test_stall();
    int d;
    prep(0);
    run_sweep(1'b1, -1, -1, d);
    check_result("stall", d, 18, 4);
  endtask

  task automatic test_restart();
    int d;
    prep(0);
    run_sweep(1'b0, 6, -1, d);
    check_result("restart", d, 14, 4);
  endtask

  task automatic test_reset_mid();
    int d;
    prep(0);
    run_sweep(1'b0, -1, 9, d);
    total++;
    if (nvw1 !== 7) $display("FAIL midreset writes_before got %0d want 7", nvw1);
    else pass_cnt++;
    @(negedge clk);
    total++;
    if (busy1 !== 1'b0 || vwe1 !== 1'b0 || we1 !== 1'b0 || done1 !== 1'b0)
      $display("FAIL midreset outputs busy%b vwe%b we%b done%b want 0000", busy1, vwe1, we1, done1);
    else pass_cnt++;
    total++;
    if (live1 !== '0) $display("FAIL midreset live_count got %0d want 0", live1);
    else pass_cnt++;
    reset = 1'b0;
    prep(0);
    run_sweep(1'b0, -1, -1, d);
    check_result("after_reset", d, 14, 4);
  endtask

  task automatic test_empty_sand();
    int d;
    prep(1);
    run_sweep(1'b0, -1, -1, d);
    check_result("empty", d, 14, 0);
    prep(2);
    run_sweep(1'b0, -1, -1, d);
    check_result("sand", d, 14, 12);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_no_clear();
    test_stall();
    test_restart();
    test_reset_mid();
    test_empty_sand();
    $display("%0d/%0d checks passed", pass_cnt, total);
    $finish;
  end

endmodule
